// File: rtl/bias_loader_pkg.sv
// bias_loader_pkg: shared state encoding, default sizes and a counter-width
// helper for the bias loader slice.
package bias_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } bias_ld_state_t;

  localparam int NUM_BIASES_DEF = 4;
  localparam int BIAS_WIDTH_DEF = 24;
  localparam int CLK_DIV_DEF    = 4;

  localparam int TB        = NUM_BIASES_DEF * BIAS_WIDTH_DEF;
  localparam int DIV_CNT_W = $clog2(CLK_DIV_DEF);
  localparam int BIT_CNT_W = $clog2(TB);

  // Counter width that never collapses to zero bits when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_loader_if.sv
// bias_loader_if: bias bus from the regfile plus the serial chain pins.
// Defining BIAS_LOADER_READBACK_EN adds the chain tail input (bias_sdi)
// and the sticky readback error flag.
interface bias_loader_if
  import bias_loader_pkg::*;
#(
  parameter int NUM_BIASES = NUM_BIASES_DEF,
  parameter int BIAS_WIDTH = BIAS_WIDTH_DEF
);

  logic [NUM_BIASES-1:0][BIAS_WIDTH-1:0] biases;
  logic                                  load_req;
  logic                                  busy;
  logic                                  bias_sck;
  logic                                  bias_sdo;
  logic                                  bias_latch;
  logic                                  load_done;
  logic [7:0]                            load_count;

`ifdef BIAS_LOADER_READBACK_EN
  logic bias_sdi;
  logic readback_err;

  modport master (
    output biases, load_req, bias_sdi,
    input  busy, bias_sck, bias_sdo, bias_latch, load_done, load_count,
           readback_err
  );

  modport slave (
    input  biases, load_req, bias_sdi,
    output busy, bias_sck, bias_sdo, bias_latch, load_done, load_count,
           readback_err
  );
`else
  modport master (
    output biases, load_req,
    input  busy, bias_sck, bias_sdo, bias_latch, load_done, load_count
  );

  modport slave (
    input  biases, load_req,
    output busy, bias_sck, bias_sdo, bias_latch, load_done, load_count
  );
`endif

endinterface

// File: rtl/bias_tick_gen.sv
// bias_tick_gen: one-cycle tick every CLK_DIV enabled cycles; the divide
// counter sits at zero while disabled so each FSM state starts a full period.
module bias_tick_gen
  import bias_loader_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLK_DIV);

  logic [CNT_W-1:0] div_cnt;

  assign tick = en && (div_cnt == CNT_W'(CLK_DIV - 1));

  // Divide counter: restarts on every tick and is parked at zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bias_loader.sv
// bias_loader: snapshots the bias bus whenever it changes (or on load_req)
// and shifts the snapshot MSB-first, top word first, into the analog bias
// chain, finishing with a latch strobe.
// Optional chain readback check: define BIAS_LOADER_READBACK_EN.
module bias_loader
  import bias_loader_pkg::*;
#(
  parameter int NUM_BIASES = NUM_BIASES_DEF,
  parameter int BIAS_WIDTH = BIAS_WIDTH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF
) (
  input logic          clk,
  input logic          rst,
  bias_loader_if.slave bus
);

  localparam int TOT_BITS = NUM_BIASES * BIAS_WIDTH;
  localparam int BIT_W    = cnt_width(TOT_BITS);

  bias_ld_state_t      state, state_n;
  logic [TOT_BITS-1:0] biases_flat;
  logic [TOT_BITS-1:0] shadow;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n, next_idx;
  logic                pending, capture, tick, last_bit, bias_diff;
  logic                busy_q, sck_q, sdo_q, latch_q, done_q;
  logic                busy_n, sck_n, sdo_n, latch_n, done_n;
  logic [7:0]          count_q;

  assign biases_flat = bus.biases;
  assign bias_diff   = (biases_flat != shadow);
  assign last_bit    = (bit_cnt == BIT_W'(TOT_BITS - 1));
  assign next_idx    = BIT_W'(TOT_BITS - 2) - bit_cnt;

  assign bus.busy       = busy_q;
  assign bus.bias_sck   = sck_q;
  assign bus.bias_sdo   = sdo_q;
  assign bus.bias_latch = latch_q;
  assign bus.load_done  = done_q;
  assign bus.load_count = count_q;

  bias_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Next-state and next-output decode; every state change waits for a tick.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    capture   = 1'b0;
    busy_n    = busy_q;
    sck_n     = sck_q;
    sdo_n     = sdo_q;
    latch_n   = latch_q;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          capture   = 1'b1;
          state_n   = SHIFT_LO;
          bit_cnt_n = '0;
          busy_n    = 1'b1;
          sck_n     = 1'b0;
          sdo_n     = biases_flat[TOT_BITS-1];
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          state_n = SHIFT_HI;
          sck_n   = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          sck_n = 1'b0;
          if (last_bit) begin
            state_n = LATCH;
            sdo_n   = 1'b0;
            latch_n = 1'b1;
          end else begin
            state_n   = SHIFT_LO;
            bit_cnt_n = bit_cnt + 1'b1;
            sdo_n     = shadow[next_idx];
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_n = IDLE;
          latch_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, snapshot, pending flag and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shadow  <= '0;
      pending <= 1'b1;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      busy_q  <= busy_n;
      sck_q   <= sck_n;
      sdo_q   <= sdo_n;
      latch_q <= latch_n;
      done_q  <= done_n;
      if (capture) begin
        shadow <= biases_flat;
      end
      // A difference seen in the capture cycle is absorbed by that snapshot.
      pending <= bus.load_req || (bias_diff && !capture) || (pending && !capture);
      if (done_n) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

`ifdef BIAS_LOADER_READBACK_EN
  logic [TOT_BITS-1:0] rb_shift;
  logic [TOT_BITS-1:0] prev_shadow;
  logic                rb_valid;
  logic                rb_err;

  assign bus.readback_err = rb_err;

  // The chain tail returns the previous frame; compare it on entry to LATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_shift    <= '0;
      prev_shadow <= '0;
      rb_valid    <= 1'b0;
      rb_err      <= 1'b0;
    end else begin
      if (capture) begin
        prev_shadow <= shadow;
      end
      if (state == SHIFT_LO && tick) begin
        rb_shift <= {rb_shift[TOT_BITS-2:0], bus.bias_sdi};
      end
      if (state == SHIFT_HI && tick && last_bit && rb_valid &&
          (rb_shift != prev_shadow)) begin
        rb_err <= 1'b1;
      end
      if (done_n) begin
        rb_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
- Downstream consumer of the `biases` bus exported by the SPI/regfile top.
- Whenever any bias word changes, or a reload is requested, the block snapshots all bias words into a shadow register.
- It then shifts the snapshot serially into the analog bias-generator chain and pulses a latch strobe at the end.
- Sits between the digital top and the analog bias DAC pads.

Parameters:
- NUM_BIASES, 4, number of bias words in the chain.
- BIAS_WIDTH, 24, bits per bias word.
- CLK_DIV, 4, clk cycles per half-period of `bias_sck`; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- biases  input  NUM_BIASES x BIAS_WIDTH  bias words from the regfile.
- load_req  input  1  one-cycle pulse; forces a reload even if the biases are unchanged.
- busy  output  1  high from snapshot capture until the end of the latch pulse.
- bias_sck  output  1  serial clock to the analog chain.
- bias_sdo  output  1  serial data to the analog chain.
- bias_latch  output  1  parallel-load strobe to the analog chain.
- load_done  output  1  one-cycle pulse when a load completes.
- load_count  output  8  number of completed loads; wraps 255 -> 0.

Interface note: one clock, `clk`; reset `rst` is asynchronous and active-high.

Behaviour:
Reset
- `rst` high: busy, bias_sck, bias_sdo, bias_latch, load_done = 0; load_count = 0; shadow = 0; state = IDLE.
- pending resets to 1, so one load is always performed after reset is released.

Pending flag
- Set on any cycle where load_req = 1, or where biases != shadow (full-width compare, registered).
- Cleared in the capture cycle.
- Set and clear in the same cycle: set wins (pending stays 1).

Shift order and data
- Word NUM_BIASES-1 first, MSB first; word 0 LSB last.
- Total bits TB = NUM_BIASES*BIAS_WIDTH (96 by default).

FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE, pending = 1: next edge copies biases into the shadow, clears bit_cnt, sets busy = 1, drives bias_sdo = first bit, enters SHIFT_LO.
- SHIFT_LO: bias_sck = 0 for CLK_DIV cycles; bias_sdo is stable for the whole state; then go to SHIFT_HI.
- SHIFT_HI: bias_sck = 1 for CLK_DIV cycles. On exit:
  - if bit_cnt = TB-1, enter LATCH;
  - otherwise bit_cnt++, bias_sdo = next bit, enter SHIFT_LO.
  - bias_sdo changes only on the clk edge where bias_sck falls.
- LATCH: bias_sck = 0, bias_sdo = 0, bias_latch = 1 for CLK_DIV cycles. On exit: IDLE, busy = 0, load_done = 1 for one cycle, load_count++.

Latency
- pending high in IDLE -> busy high one cycle later.
- busy stays high for exactly 2*CLK_DIV*TB + CLK_DIV cycles (772 at defaults).
- load_done is asserted in the first cycle busy is low.

Boundary conditions
- Biases change mid-load: the current load is never aborted; pending sets and a new load starts from IDLE one cycle after load_done.
- load_req while busy: pending is set; exactly one extra load follows, however many pulses arrive.
- Several biases change in the same cycle: a single load covers all of them.
- rst mid-load: all outputs drop asynchronously; after release a fresh full load runs (pending = 1).
- CLK_DIV = 1: bias_sck toggles every clk cycle; busy lasts 2*TB+1 cycles.

Optional Feature:
- Macro: BIAS_LOADER_READBACK_EN.
- Enabled:
  - Adds input `bias_sdi` (chain tail output) and output `readback_err` (sticky, resets to 0).
  - `bias_sdi` is sampled on the clk edge where bias_sck rises; samples are shifted into a TB-bit readback register.
  - On entering LATCH, the register is compared against the previous load's shadow, since the chain returns prior contents. A mismatch sets readback_err.
  - The first load after reset skips the compare.
  - readback_err clears only on rst.
- Disabled: neither port exists; no readback register is synthesized.

Decomposition:
- Package `bias_loader_pkg`:
  - state enum `bias_ld_state_t` {IDLE, SHIFT_LO, SHIFT_HI, LATCH};
  - localparams for TB and for the counter widths ($clog2(CLK_DIV), $clog2(TB)).
- Sub-module `bias_tick_gen`:
  - divide counter that emits a one-cycle `tick` every CLK_DIV cycles while enabled;
  - held at 0 while disabled.
- The FSM advances state only on `tick`.

Test Plan:
- Release rst with biases {0xAAAAAA,0x555555,0xF0F0F0,0x0F0F0F} (words 0..3) -> one 96-bit frame with words 3,2,1,0 MSB-first, 96 sck rising edges, one latch pulse of 4 clk, load_done once, load_count = 1, busy width 772.
- Steady biases, then a load_req pulse -> identical frame re-sent, load_count = 2; no further loads without stimulus.
- Change bias[2] to 0x123456 at bit 40 of a load -> first frame completes unchanged; second frame carrying 0x123456 starts exactly 1 cycle after load_done.
- Assert rst at bit 50 -> all outputs 0 in the same cycle, load_count = 0; after release, a full frame runs.
- CLK_DIV = 1, three load_req pulses while busy -> exactly one extra load; sck period 2 clk; busy = 193 cycles.
- BIAS_LOADER_READBACK_EN: loopback model returning the prior frame -> readback_err stays 0. Flip one returned bit -> readback_err = 1 and stays set until rst.
